// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with run/halt control and wrap flag
module pc_reg #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             skip,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_addr,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic             halted,
    output logic             wrap
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [WIDTH:0] INC_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] INC_TWO = (WIDTH+1)'(2);

    state_t         state;
    logic [WIDTH:0] sum_one;
    logic [WIDTH:0] sum_two;

    // Carry-extended increments; the top bit is the wrap indication
    always_comb begin
        sum_one = {1'b0, pc} + INC_ONE;
        sum_two = {1'b0, pc} + INC_TWO;
    end

    // Run/halt FSM with registered pc, halted and wrap outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            pc     <= RESET_VEC;
            halted <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                RUN: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (ld) begin
                        pc <= ld_addr;
                    end else if (skip) begin
                        pc   <= sum_two[WIDTH-1:0];
                        wrap <= sum_two[WIDTH];
                    end else if (en) begin
                        pc   <= sum_one[WIDTH-1:0];
                        wrap <= sum_one[WIDTH];
                    end
                end
                HALTED: begin
                    // Only a jump leaves HALTED; halt in the same cycle does not block it
                    if (ld) begin
                        state  <= RUN;
                        halted <= 1'b0;
                        pc     <= ld_addr;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
